tcm_ctrl_arb: RTL and testbench
===============================

Name: tcm_ctrl_arb

Overview:
- Parametrised tightly-coupled memory controller, successor of the fixed 64KB TCM wrapper.
- Owns a true dual-port RAM:
  - port 0: instruction fetch.
  - port 1: arbitrated between CPU data accesses and an external (debug/DMA) master.
- CPU data accesses outside the TCM window are forwarded to the mem_out bus, with a bounded outstanding-request count.
- Adds fair arbitration, a registered external ack, and a configurable address window.

Parameters:
RAM_AW, 14, word-address width; RAM holds 2^RAM_AW 32-bit words, indexed by addr[RAM_AW+1:2]
TCM_BASE, 32'h00000000, base of TCM window
TCM_MASK, 32'h80000000, decode mask; address is internal iff (addr & TCM_MASK) == TCM_BASE
EXT_STREAK_MAX, 4, max consecutive external grants while a CPU internal request waits (>=1)
OUT_MAX, 2, max outstanding mem_out requests (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_i_rd_i  in  1  fetch request
mem_i_pc_i  in  32  fetch address
mem_i_accept_o  out  1  fetch accept, tied 1
mem_i_valid_o  out  1  fetch data valid
mem_i_inst_o  out  32  fetched word
mem_d_addr_i  in  32  CPU data address
mem_d_data_wr_i  in  32  CPU write data
mem_d_rd_i  in  1  CPU read request
mem_d_wr_i  in  4  CPU byte write enables
mem_d_req_tag_i  in  11  CPU request tag
mem_d_accept_o  out  1  CPU request accepted this cycle
mem_d_ack_o  out  1  CPU response valid
mem_d_resp_tag_o  out  11  response tag
mem_d_data_rd_o  out  32  response read data
ext_addr_i  in  32  external address
ext_write_data_i  in  32  external write data
ext_rd_i  in  1  external read request
ext_wr_i  in  4  external byte write enables
ext_accept_o  out  1  external request granted this cycle
ext_ack_o  out  1  external response valid
ext_read_data_o  out  32  external read data, valid with ext_ack_o
mem_out_addr_o  out  32  forwarded address, = mem_d_addr_i
mem_out_data_wr_o  out  32  forwarded write data, = mem_d_data_wr_i
mem_out_rd_o  out  1  forwarded read
mem_out_wr_o  out  4  forwarded write enables
mem_out_req_tag_o  out  11  forwarded tag, = mem_d_req_tag_i
mem_out_accept_i  in  1  downstream accept
mem_out_ack_i  in  1  downstream response valid
mem_out_resp_tag_i  in  11  downstream response tag
mem_out_data_rd_i  in  32  downstream read data
mem_out_resp_accept_o  out  1  downstream response accept

Behaviour:

Reset and fetch port
- Reset clears to 0: mem_i_valid_q, int_ack_q, ext_ack_q, int_tag_q, ext_streak_q, out_cnt_q.
- After reset: all request/ack outputs are 0; mem_i_accept_o=1; mem_out_resp_accept_o=1.
- Fetch: RAM port 0 read is registered. mem_i_valid_o = mem_i_rd_i delayed 1 cycle. Fetch is never stalled.

Decode and request signals
- int_req = (mem_d_rd_i | mem_d_wr_i!=0) & internal decode.
- ext_req = ext_rd_i | ext_wr_i!=0.

Port-1 arbitration (combinational, same cycle)
- cpu_win = int_req & (!ext_req | ext_streak_q==EXT_STREAK_MAX).
- ext_accept_o = ext_req & !cpu_win.
- Internal accept = int_req & !ext_accept_o.
- ext_streak_q:
  - increments when ext_accept_o & int_req;
  - clears when int_req is accepted or int_req=0;
  - saturates at EXT_STREAK_MAX.
- Port-1 mux: address, data and byte enables come from the granted source. Write enables are 0 when nothing is granted.

Internal response
- int_ack_q=1 for 1 cycle after an internal accept.
- int_tag_q captures the request tag.
- RAM data appears with int_ack_q (1-cycle latency).
- Internal writes also ack.

External response
- ext_ack_q=1 for 1 cycle after ext_accept_o.
- ext_read_data_o = port-1 RAM data during that cycle; don't-care otherwise.

External (non-TCM) forwarding
- Outstanding limit: if out_cnt_q==OUT_MAX, mem_out_rd_o=0, mem_out_wr_o=0 and mem_d_accept_o=0.
- Otherwise: mem_out_rd_o/wr_o pass CPU rd/wr, and mem_d_accept_o = mem_out_accept_i.
- out_cnt_q:
  - +1 on a forwarded request with mem_out_accept_i;
  - -1 on mem_out_ack_i & mem_out_resp_accept_o;
  - both in the same cycle: unchanged.
  - Never exceeds OUT_MAX or goes below 0.

Response mux
- mem_out_resp_accept_o = !int_ack_q.
- mem_d_ack_o = int_ack_q | (mem_out_ack_i & !int_ack_q).
- While int_ack_q=1: tag = int_tag_q, data = RAM port-1 data. Otherwise tag and data come from mem_out.
- A mem_out response stalled by int_ack_q must be held by downstream and is delivered the next cycle.

Reset mid-operation
- In-flight acks are dropped and out_cnt_q returns to 0.
- Downstream must also be reset.

Test Plan:
1. Reset with all inputs 0 -> every ack/valid/rd/wr output 0, mem_i_accept_o=1, mem_out_resp_accept_o=1, counters 0.
2. CPU write 0xDEADBEEF, wr=4'hF, addr 0x100, tag 5; next cycle read addr 0x100, tag 6 -> acks 1 cycle after each accept with tags 5 and 6; read data 0xDEADBEEF; fetch of PC 0x100 returns the same word.
3. EXT_STREAK_MAX=4, ext_rd_i held high, CPU internal read pending -> ext_accept_o=1 for 4 cycles, CPU accepted on cycle 5, ext regranted on cycle 6.
4. OUT_MAX=2, mem_out_accept_i=1, mem_out_ack_i=0, three CPU reads to 0x80000000 -> first two forwarded; third held with mem_d_accept_o=0 until one mem_out ack arrives.
5. Internal ack and mem_out_ack_i (tag 9) in the same cycle -> internal response delivered, mem_out_resp_accept_o=0; tag 9 delivered next cycle.
6. Assert rst_i for 1 cycle while int_ack_q=1 and out_cnt_q=2 -> next cycle mem_d_ack_o=0, out_cnt_q=0.

Source files
------------

// File: rtl/tcm_ctrl_arb_if.sv
// Bus bundle for the TCM controller: fetch, CPU data, external master and mem_out.
// The slave modport is the controller's view; master is the environment's view.
interface tcm_ctrl_arb_if;
    logic        mem_i_rd_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic [31:0] mem_i_inst_o;

    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic [10:0] mem_d_resp_tag_o;
    logic [31:0] mem_d_data_rd_o;

    logic [31:0] ext_addr_i;
    logic [31:0] ext_write_data_i;
    logic        ext_rd_i;
    logic [3:0]  ext_wr_i;
    logic        ext_accept_o;
    logic        ext_ack_o;
    logic [31:0] ext_read_data_o;

    logic [31:0] mem_out_addr_o;
    logic [31:0] mem_out_data_wr_o;
    logic        mem_out_rd_o;
    logic [3:0]  mem_out_wr_o;
    logic [10:0] mem_out_req_tag_o;
    logic        mem_out_accept_i;
    logic        mem_out_ack_i;
    logic [10:0] mem_out_resp_tag_i;
    logic [31:0] mem_out_data_rd_i;
    logic        mem_out_resp_accept_o;

    modport slave (
        input  mem_i_rd_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_req_tag_i,
        output mem_d_accept_o, mem_d_ack_o, mem_d_resp_tag_o, mem_d_data_rd_o,
        input  ext_addr_i, ext_write_data_i, ext_rd_i, ext_wr_i,
        output ext_accept_o, ext_ack_o, ext_read_data_o,
        output mem_out_addr_o, mem_out_data_wr_o, mem_out_rd_o, mem_out_wr_o, mem_out_req_tag_o,
        input  mem_out_accept_i, mem_out_ack_i, mem_out_resp_tag_i, mem_out_data_rd_i,
        output mem_out_resp_accept_o
    );

    modport master (
        output mem_i_rd_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_req_tag_i,
        input  mem_d_accept_o, mem_d_ack_o, mem_d_resp_tag_o, mem_d_data_rd_o,
        output ext_addr_i, ext_write_data_i, ext_rd_i, ext_wr_i,
        input  ext_accept_o, ext_ack_o, ext_read_data_o,
        input  mem_out_addr_o, mem_out_data_wr_o, mem_out_rd_o, mem_out_wr_o, mem_out_req_tag_o,
        output mem_out_accept_i, mem_out_ack_i, mem_out_resp_tag_i, mem_out_data_rd_i,
        input  mem_out_resp_accept_o
    );
endinterface

// File: rtl/tcm_ctrl_arb.sv
// Tightly-coupled memory controller: dual-port RAM with fetch on port 0, CPU/external
// arbitration on port 1, and forwarding of non-TCM CPU accesses to mem_out.
module tcm_ctrl_arb #(
    parameter int          RAM_AW         = 14,
    parameter logic [31:0] TCM_BASE       = 32'h0000_0000,
    parameter logic [31:0] TCM_MASK       = 32'h8000_0000,
    parameter int          EXT_STREAK_MAX = 4,
    parameter int          OUT_MAX        = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tcm_ctrl_arb_if.slave  bus
);
    localparam int SW = $clog2(EXT_STREAK_MAX + 1);
    localparam int CW = $clog2(OUT_MAX + 1);

    logic [31:0] ram_q [2**RAM_AW];
    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;

    logic          mem_i_valid_q, mem_i_valid_d;
    logic          int_ack_q, int_ack_d;
    logic          ext_ack_q, ext_ack_d;
    logic [10:0]   int_tag_q, int_tag_d;
    logic [SW-1:0] ext_streak_q, ext_streak_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    logic d_req, internal, int_req, out_req, ext_req;
    logic cpu_win, ext_grant, int_grant;
    logic out_full, out_fwd, out_ret;

    logic [RAM_AW-1:0] p0_idx, p1_idx;
    logic [31:0]       p1_wdata;
    logic [3:0]        p1_we;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_i_pc_i[31:RAM_AW+2], bus.mem_i_pc_i[1:0],
                           bus.ext_addr_i[31:RAM_AW+2], bus.ext_addr_i[1:0]};

    // External master is assumed to always target the TCM, so its address is not decoded.
    assign internal  = (bus.mem_d_addr_i & TCM_MASK) == TCM_BASE;
    assign d_req     = bus.mem_d_rd_i | (bus.mem_d_wr_i != 4'h0);
    assign int_req   = d_req & internal;
    assign out_req   = d_req & ~internal;
    assign ext_req   = bus.ext_rd_i | (bus.ext_wr_i != 4'h0);

    assign cpu_win   = int_req & (~ext_req | (ext_streak_q == SW'(EXT_STREAK_MAX)));
    assign ext_grant = ext_req & ~cpu_win;
    assign int_grant = int_req & ~ext_grant;

    assign out_full  = out_cnt_q == CW'(OUT_MAX);
    assign out_fwd   = out_req & ~out_full & bus.mem_out_accept_i;
    assign out_ret   = bus.mem_out_ack_i & bus.mem_out_resp_accept_o;

    assign p0_idx = bus.mem_i_pc_i[RAM_AW+1:2];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        p1_idx   = bus.mem_d_addr_i[RAM_AW+1:2];
        p1_wdata = bus.mem_d_data_wr_i;
        p1_we    = 4'h0;
        if (ext_grant) begin
            p1_idx   = bus.ext_addr_i[RAM_AW+1:2];
            p1_wdata = bus.ext_write_data_i;
            p1_we    = bus.ext_wr_i;
        end else if (int_grant) begin
            p1_we    = bus.mem_d_wr_i;
        end
    end

    // NOTE: the RAM array has no reset; contents are undefined until written, which
    // lets it map onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (p1_we[b]) ram_q[p1_idx][b*8 +: 8] <= p1_wdata[b*8 +: 8];
        end
        p0_rdata_q <= ram_q[p0_idx];
        p1_rdata_q <= ram_q[p1_idx];
    end

    always_comb begin
        mem_i_valid_d = bus.mem_i_rd_i;
        int_ack_d     = int_grant;
        ext_ack_d     = ext_grant;
        int_tag_d     = int_grant ? bus.mem_d_req_tag_i : int_tag_q;

        ext_streak_d = ext_streak_q;
        if (ext_grant && int_req) begin
            if (ext_streak_q != SW'(EXT_STREAK_MAX)) ext_streak_d = ext_streak_q + 1'b1;
        end else if (int_grant || !int_req) begin
            ext_streak_d = '0;
        end

        out_cnt_d = out_cnt_q;
        if (out_fwd && !out_ret) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (out_ret && !out_fwd && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_i_valid_q <= 1'b0;
            int_ack_q     <= 1'b0;
            ext_ack_q     <= 1'b0;
            int_tag_q     <= '0;
            ext_streak_q  <= '0;
            out_cnt_q     <= '0;
        end else begin
            mem_i_valid_q <= mem_i_valid_d;
            int_ack_q     <= int_ack_d;
            ext_ack_q     <= ext_ack_d;
            int_tag_q     <= int_tag_d;
            ext_streak_q  <= ext_streak_d;
            out_cnt_q     <= out_cnt_d;
        end
    end

    assign bus.mem_i_accept_o = 1'b1;
    assign bus.mem_i_valid_o  = mem_i_valid_q;
    assign bus.mem_i_inst_o   = p0_rdata_q;

    assign bus.ext_accept_o    = ext_grant;
    assign bus.ext_ack_o       = ext_ack_q;
    assign bus.ext_read_data_o = p1_rdata_q;

    assign bus.mem_out_addr_o    = bus.mem_d_addr_i;
    assign bus.mem_out_data_wr_o = bus.mem_d_data_wr_i;
    assign bus.mem_out_req_tag_o = bus.mem_d_req_tag_i;
    assign bus.mem_out_rd_o      = out_req & ~out_full & bus.mem_d_rd_i;
    assign bus.mem_out_wr_o      = (out_req & ~out_full) ? bus.mem_d_wr_i : 4'h0;

    assign bus.mem_d_accept_o = int_grant | out_fwd;

    // Internal responses take priority; a colliding mem_out response is held downstream.
    assign bus.mem_out_resp_accept_o = ~int_ack_q;
    assign bus.mem_d_ack_o           = int_ack_q | bus.mem_out_ack_i;
    assign bus.mem_d_resp_tag_o      = int_ack_q ? int_tag_q  : bus.mem_out_resp_tag_i;
    assign bus.mem_d_data_rd_o       = int_ack_q ? p1_rdata_q : bus.mem_out_data_rd_i;
endmodule

// File: tb/tb_tcm_ctrl_arb.sv
// Directed bench for tcm_ctrl_arb: reset, RAM round trip, arbitration fairness,
// outstanding limit, response collision and mid-operation reset.
module tb_tcm_ctrl_arb;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    tcm_ctrl_arb_if bus ();

    tcm_ctrl_arb #(
        .RAM_AW(14), .TCM_BASE(32'h0), .TCM_MASK(32'h8000_0000),
        .EXT_STREAK_MAX(4), .OUT_MAX(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_i_rd_i         = 1'b0;
        bus.mem_i_pc_i         = '0;
        bus.mem_d_addr_i       = '0;
        bus.mem_d_data_wr_i    = '0;
        bus.mem_d_rd_i         = 1'b0;
        bus.mem_d_wr_i         = '0;
        bus.mem_d_req_tag_i    = '0;
        bus.ext_addr_i         = '0;
        bus.ext_write_data_i   = '0;
        bus.ext_rd_i           = 1'b0;
        bus.ext_wr_i           = '0;
        bus.mem_out_accept_i   = 1'b0;
        bus.mem_out_ack_i      = 1'b0;
        bus.mem_out_resp_tag_i = '0;
        bus.mem_out_data_rd_i  = '0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        settle();

        // Reset state
        check("rst_d_ack",      32'(bus.mem_d_ack_o), 32'd0);
        check("rst_ext_ack",    32'(bus.ext_ack_o), 32'd0);
        check("rst_i_valid",    32'(bus.mem_i_valid_o), 32'd0);
        check("rst_out_rd",     32'(bus.mem_out_rd_o), 32'd0);
        check("rst_out_wr",     32'(bus.mem_out_wr_o), 32'd0);
        check("rst_ext_acc",    32'(bus.ext_accept_o), 32'd0);
        check("rst_d_acc",      32'(bus.mem_d_accept_o), 32'd0);
        check("rst_i_acc",      32'(bus.mem_i_accept_o), 32'd1);
        check("rst_resp_acc",   32'(bus.mem_out_resp_accept_o), 32'd1);
        check("rst_out_cnt",    32'(dut.out_cnt_q), 32'd0);
        check("rst_streak",     32'(dut.ext_streak_q), 32'd0);

        // CPU write then read of 0x100, plus fetch of the same word
        tick();
        bus.mem_d_addr_i    = 32'h100;
        bus.mem_d_data_wr_i = 32'hDEAD_BEEF;
        bus.mem_d_wr_i      = 4'hF;
        bus.mem_d_req_tag_i = 11'd5;
        settle();
        check("wr_accept",  32'(bus.mem_d_accept_o), 32'd1);
        check("wr_no_fwd",  32'(bus.mem_out_wr_o), 32'd0);
        tick();
        bus.mem_d_wr_i      = 4'h0;
        bus.mem_d_rd_i      = 1'b1;
        bus.mem_d_req_tag_i = 11'd6;
        bus.mem_i_rd_i      = 1'b1;
        bus.mem_i_pc_i      = 32'h100;
        settle();
        check("wr_ack",     32'(bus.mem_d_ack_o), 32'd1);
        check("wr_tag",     32'(bus.mem_d_resp_tag_o), 32'd5);
        check("rd_accept",  32'(bus.mem_d_accept_o), 32'd1);
        tick();
        idle_inputs();
        settle();
        check("rd_ack",     32'(bus.mem_d_ack_o), 32'd1);
        check("rd_tag",     32'(bus.mem_d_resp_tag_o), 32'd6);
        check("rd_data",    bus.mem_d_data_rd_o, 32'hDEAD_BEEF);
        check("fetch_vld",  32'(bus.mem_i_valid_o), 32'd1);
        check("fetch_inst", bus.mem_i_inst_o, 32'hDEAD_BEEF);
        tick();
        settle();
        check("rd_ack_done", 32'(bus.mem_d_ack_o), 32'd0);
        check("fetch_done",  32'(bus.mem_i_valid_o), 32'd0);

        // Arbitration: ext wins 4 times, then CPU, then ext again
        bus.ext_rd_i        = 1'b1;
        bus.ext_addr_i      = 32'h100;
        bus.mem_d_rd_i      = 1'b1;
        bus.mem_d_addr_i    = 32'h100;
        bus.mem_d_req_tag_i = 11'd7;
        for (int i = 1; i <= 4; i++) begin
            settle();
            check($sformatf("arb_ext_c%0d", i), 32'(bus.ext_accept_o), 32'd1);
            check($sformatf("arb_cpu_c%0d", i), 32'(bus.mem_d_accept_o), 32'd0);
            tick();
        end
        settle();
        check("arb_ext_c5",   32'(bus.ext_accept_o), 32'd0);
        check("arb_cpu_c5",   32'(bus.mem_d_accept_o), 32'd1);
        check("arb_ext_ack",  32'(bus.ext_ack_o), 32'd1);
        check("arb_ext_data", bus.ext_read_data_o, 32'hDEAD_BEEF);
        tick();
        settle();
        check("arb_ext_c6",   32'(bus.ext_accept_o), 32'd1);
        check("arb_cpu_c6",   32'(bus.mem_d_accept_o), 32'd0);
        check("arb_cpu_ack",  32'(bus.mem_d_ack_o), 32'd1);
        check("arb_cpu_tag",  32'(bus.mem_d_resp_tag_o), 32'd7);
        check("arb_cpu_data", bus.mem_d_data_rd_o, 32'hDEAD_BEEF);
        check("arb_ext_noack", 32'(bus.ext_ack_o), 32'd0);
        tick();
        idle_inputs();
        tick();

        // External single-byte write on lane 1: DEADBEEF -> DEADABEF
        bus.ext_wr_i         = 4'b0010;
        bus.ext_addr_i       = 32'h100;
        bus.ext_write_data_i = 32'h0000_AB00;
        settle();
        check("bw_ext_acc", 32'(bus.ext_accept_o), 32'd1);
        tick();
        idle_inputs();
        bus.mem_i_rd_i = 1'b1;
        bus.mem_i_pc_i = 32'h100;
        settle();
        check("bw_ext_ack", 32'(bus.ext_ack_o), 32'd1);
        tick();
        bus.mem_i_rd_i = 1'b0;
        settle();
        check("bw_fetch",   bus.mem_i_inst_o, 32'hDEAD_ABEF);

        // Outstanding limit of 2 on mem_out
        bus.mem_out_accept_i = 1'b1;
        bus.mem_d_rd_i       = 1'b1;
        bus.mem_d_addr_i     = 32'h8000_0000;
        bus.mem_d_req_tag_i  = 11'd1;
        settle();
        check("out1_rd",  32'(bus.mem_out_rd_o), 32'd1);
        check("out1_acc", 32'(bus.mem_d_accept_o), 32'd1);
        check("out1_addr", bus.mem_out_addr_o, 32'h8000_0000);
        tick();
        bus.mem_d_req_tag_i = 11'd2;
        settle();
        check("out2_rd",  32'(bus.mem_out_rd_o), 32'd1);
        check("out2_acc", 32'(bus.mem_d_accept_o), 32'd1);
        check("out2_tag", 32'(bus.mem_out_req_tag_o), 32'd2);
        tick();
        bus.mem_d_req_tag_i = 11'd3;
        settle();
        check("out3_rd_held",  32'(bus.mem_out_rd_o), 32'd0);
        check("out3_acc_held", 32'(bus.mem_d_accept_o), 32'd0);
        check("out3_cnt",      32'(dut.out_cnt_q), 32'd2);
        tick();
        bus.mem_out_ack_i      = 1'b1;
        bus.mem_out_resp_tag_i = 11'd1;
        bus.mem_out_data_rd_i  = 32'h1111_1111;
        settle();
        check("out_ret_rd_held", 32'(bus.mem_out_rd_o), 32'd0);
        check("out_ret_ack",     32'(bus.mem_d_ack_o), 32'd1);
        check("out_ret_tag",     32'(bus.mem_d_resp_tag_o), 32'd1);
        check("out_ret_data",    bus.mem_d_data_rd_o, 32'h1111_1111);
        tick();
        bus.mem_out_ack_i = 1'b0;
        settle();
        check("out3_rd",  32'(bus.mem_out_rd_o), 32'd1);
        check("out3_acc", 32'(bus.mem_d_accept_o), 32'd1);
        tick();
        idle_inputs();
        settle();
        check("out_cnt_full", 32'(dut.out_cnt_q), 32'd2);

        // Internal ack colliding with a mem_out response (tag 9)
        bus.mem_d_rd_i      = 1'b1;
        bus.mem_d_addr_i    = 32'h100;
        bus.mem_d_req_tag_i = 11'h0AA;
        settle();
        check("col_acc", 32'(bus.mem_d_accept_o), 32'd1);
        tick();
        idle_inputs();
        bus.mem_out_ack_i      = 1'b1;
        bus.mem_out_resp_tag_i = 11'd9;
        bus.mem_out_data_rd_i  = 32'h9999_9999;
        settle();
        check("col_int_ack",  32'(bus.mem_d_ack_o), 32'd1);
        check("col_int_tag",  32'(bus.mem_d_resp_tag_o), 32'h0AA);
        check("col_int_data", bus.mem_d_data_rd_o, 32'hDEAD_ABEF);
        check("col_resp_acc", 32'(bus.mem_out_resp_accept_o), 32'd0);
        tick();
        settle();
        check("col_out_ack",  32'(bus.mem_d_ack_o), 32'd1);
        check("col_out_tag",  32'(bus.mem_d_resp_tag_o), 32'd9);
        check("col_out_data", bus.mem_d_data_rd_o, 32'h9999_9999);
        check("col_resp_acc2", 32'(bus.mem_out_resp_accept_o), 32'd1);
        check("col_cnt_hold", 32'(dut.out_cnt_q), 32'd2);
        tick();
        idle_inputs();
        settle();
        check("col_cnt_dec",  32'(dut.out_cnt_q), 32'd1);

        // Refill to 2 outstanding, issue an internal read, then reset mid-flight
        bus.mem_out_accept_i = 1'b1;
        bus.mem_d_rd_i       = 1'b1;
        bus.mem_d_addr_i     = 32'h8000_0004;
        bus.mem_d_req_tag_i  = 11'd4;
        tick();
        bus.mem_d_addr_i     = 32'h100;
        bus.mem_d_req_tag_i  = 11'h0BB;
        tick();
        idle_inputs();
        rst_i = 1'b1;
        settle();
        check("mid_pre_ack", 32'(bus.mem_d_ack_o), 32'd1);
        check("mid_pre_cnt", 32'(dut.out_cnt_q), 32'd2);
        tick();
        rst_i = 1'b0;
        settle();
        check("mid_ack",  32'(bus.mem_d_ack_o), 32'd0);
        check("mid_cnt",  32'(dut.out_cnt_q), 32'd0);
        check("mid_resp_acc", 32'(bus.mem_out_resp_accept_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
